// File: rtl/kv_mem_pkg.sv
// Shared types and helpers for the cache-side memory responder.
// Holds the FSM state encoding and the line-geometry helpers.
package kv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP,
        WRITE
    } kv_fill_state_e;

    function automatic int unsigned lineoffset_width(input int unsigned line_size);
        return $clog2(line_size);
    endfunction

    // Addresses up to 64 bits wide are aligned; callers cast back to their own width.
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned off_w);
        logic [63:0] mask;
        mask = '1;
        mask = mask << off_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/kv_line_fill_responder.sv
// Memory-side responder: serves whole-line fills by reading LINE_SIZE words,
// and drains whole-line writebacks into the word memory one word per cycle.
module kv_line_fill_responder
    import kv_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_SIZE  = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [ADDR_WIDTH-1:0]            i_req_addr,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    output logic [DATA_WIDTH-1:0]            o_rsp_data [LINE_SIZE],
    output logic                             o_rsp_valid,
    input  logic                             i_rsp_ready,
    input  logic [ADDR_WIDTH-1:0]            i_wb_addr,
    input  logic [DATA_WIDTH*LINE_SIZE-1:0]  i_wb_data,
    input  logic                             i_wb_valid,
    output logic                             o_wb_ready,
    output logic                             o_mem_en,
    output logic                             o_mem_we,
    output logic [ADDR_WIDTH-1:0]            o_mem_addr,
    output logic [DATA_WIDTH-1:0]            o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]            i_mem_rdata
);

    localparam int unsigned OFF_W = lineoffset_width(LINE_SIZE);
    localparam int unsigned CNT_W = OFF_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(LINE_SIZE);

    kv_fill_state_e state, state_next;

    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] aligned_req;
    logic [ADDR_WIDTH-1:0] aligned_wb;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      cap_cnt;
    logic                  rd_pending;
    logic [OFF_W-1:0]      word_sel;
    logic                  req_fire;
    logic                  wb_fire;
    logic [DATA_WIDTH-1:0] line_buf [LINE_SIZE];
    logic [DATA_WIDTH-1:0] wb_line  [LINE_SIZE];

    assign aligned_req = ADDR_WIDTH'(line_base(64'(i_req_addr), OFF_W));
    assign aligned_wb  = ADDR_WIDTH'(line_base(64'(i_wb_addr), OFF_W));
    assign word_sel    = issue_cnt[OFF_W-1:0];
    assign o_rsp_data  = line_buf;

    always_comb begin
        state_next  = state;
        o_req_ready = 1'b0;
        o_wb_ready  = 1'b0;
        o_rsp_valid = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        req_fire    = 1'b0;
        wb_fire     = 1'b0;
        unique case (state)
            IDLE: begin
                o_wb_ready  = 1'b1;
                o_req_ready = ~i_wb_valid;
                wb_fire     = i_wb_valid;
                req_fire    = i_req_valid & ~i_wb_valid;
                if (wb_fire) begin
                    state_next = WRITE;
                end else if (req_fire) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (issue_cnt != CNT_END) begin
                    o_mem_en   = 1'b1;
                    o_mem_addr = base_addr + ADDR_WIDTH'(word_sel);
                end
                // Leave only once the last word's read data has been captured.
                if (rd_pending && cap_cnt == CNT_LAST) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                o_mem_en    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = base_addr + ADDR_WIDTH'(word_sel);
                o_mem_wdata = wb_line[word_sel];
                if (issue_cnt == CNT_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            base_addr  <= '0;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            rd_pending <= 1'b0;
            for (int unsigned i = 0; i < LINE_SIZE; i++) begin
                line_buf[i] <= '0;
                wb_line[i]  <= '0;
            end
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    issue_cnt  <= '0;
                    cap_cnt    <= '0;
                    rd_pending <= 1'b0;
                    if (wb_fire) begin
                        base_addr <= aligned_wb;
                        for (int unsigned i = 0; i < LINE_SIZE; i++) begin
                            wb_line[i] <= i_wb_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end else if (req_fire) begin
                        base_addr <= aligned_req;
                    end
                end
                READ: begin
                    rd_pending <= (issue_cnt != CNT_END);
                    if (issue_cnt != CNT_END) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                    // Read data arrives one cycle after its issue, so capture trails issue.
                    if (rd_pending) begin
                        line_buf[cap_cnt[OFF_W-1:0]] <= i_mem_rdata;
                        cap_cnt                      <= cap_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    issue_cnt <= issue_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
